// File: rtl/vga_fb_scanout.sv
// 640x480@60 VGA scan-out of an 80x60 cell, 3-bit colour video RAM.
// Counters -> address register -> synchronous RAM -> output registers; 3-cycle fixed latency.
module vga_fb_scanout #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CELL_SHIFT = 3,
  parameter int FB_WIDTH   = 80,
  parameter int ADDR_W     = 13
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oReadAddress,
  input  logic [2:0]        iReadData,
  output logic              oVGA_HS,
  output logic              oVGA_VS,
  output logic              oVGA_R,
  output logic              oVGA_G,
  output logic              oVGA_B,
  output logic              oFrameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic fs;
  } flags_t;

  // Syncs idle high so the pipeline fill never shows a partial pulse.
  localparam flags_t FLAGS_RST = 4'b0110;

  logic [HCW-1:0]    r_hcount;
  logic [VCW-1:0]    r_vcount;
  flags_t [1:0]      r_pipe;
  flags_t            w_flags;
  logic              w_visible, w_hs_raw, w_vs_raw, w_fs_raw;
  logic [ADDR_W-1:0] w_row, w_col, w_row_mul, w_addr;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (r_hcount == HCW'(H_TOTAL - 1)) begin
      r_hcount <= '0;
      r_vcount <= (r_vcount == VCW'(V_TOTAL - 1)) ? '0 : r_vcount + 1'b1;
    end else begin
      r_hcount <= r_hcount + 1'b1;
    end
  end

  assign w_visible = (r_hcount < HCW'(H_VISIBLE)) && (r_vcount < VCW'(V_VISIBLE));
  assign w_hs_raw  = !((r_hcount >= HCW'(H_VISIBLE + H_FP)) &&
                       (r_hcount <  HCW'(H_VISIBLE + H_FP + H_SYNC)));
  assign w_vs_raw  = !((r_vcount >= VCW'(V_VISIBLE + V_FP)) &&
                       (r_vcount <  VCW'(V_VISIBLE + V_FP + V_SYNC)));
  assign w_fs_raw  = (r_hcount == '0) && (r_vcount == '0);
  assign w_flags   = {w_visible, w_hs_raw, w_vs_raw, w_fs_raw};

  assign w_row = ADDR_W'(r_vcount >> CELL_SHIFT);
  assign w_col = ADDR_W'(r_hcount >> CELL_SHIFT);

  // The 80-wide buffer multiplies with two shifts; other widths use a plain multiply.
  if (FB_WIDTH == 80) begin : g_mul80
    assign w_row_mul = (w_row << 6) + (w_row << 4);
  end else begin : g_mul
    assign w_row_mul = w_row * ADDR_W'(FB_WIDTH);
  end

  assign w_addr = w_row_mul + w_col;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oReadAddress <= '0;
      r_pipe       <= {FLAGS_RST, FLAGS_RST};
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_R       <= 1'b0;
      oVGA_G       <= 1'b0;
      oVGA_B       <= 1'b0;
      oFrameStart  <= 1'b0;
    end else begin
      oReadAddress <= w_visible ? w_addr : '0;
      r_pipe       <= {r_pipe[0], w_flags};
      oVGA_HS      <= r_pipe[1].hs;
      oVGA_VS      <= r_pipe[1].vs;
      {oVGA_R, oVGA_G, oVGA_B} <= r_pipe[1].vis ? iReadData : 3'b000;
      oFrameStart  <= r_pipe[1].fs;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench: full-size scan-out plus a scaled-timing instance so whole frames fit the cycle budget.
// Expected pins/addresses are derived from the pixel index with plain div/mod arithmetic.
module tb_vga_fb_scanout;

  typedef struct packed {
    int hv; int hf; int hsw; int hb;
    int vv; int vf; int vsw; int vb;
    int fbw;
  } tcfg_t;

  localparam tcfg_t CFG_B = '{hv:640, hf:16, hsw:96, hb:48, vv:480, vf:10, vsw:2, vb:33, fbw:80};
  localparam tcfg_t CFG_S = '{hv:64,  hf:8,  hsw:16, hb:8,  vv:32,  vf:3,  vsw:2, vb:4,  fbw:8};
  localparam int HT_S  = 96;
  localparam int FRM_S = 96 * 41;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [12:0] addr_b, addr_s;
  logic [2:0]  rd_b, rd_s;
  logic        hs_b, vs_b, r_b, g_b, b_b, fs_b;
  logic        hs_s, vs_s, r_s, g_s, b_s, fs_s;
  logic [5:0]  pins_b, pins_s;
  logic [2:0]  mem_b [4800];
  logic [2:0]  mem_s [32];
  bit          white = 1'b0;
  int          k;
  int          n_checks = 0;
  int          n_fail = 0;

  always #20 Clock = ~Clock;

  vga_fb_scanout u_big (
    .Clock(Clock), .Reset(Reset), .oReadAddress(addr_b), .iReadData(rd_b),
    .oVGA_HS(hs_b), .oVGA_VS(vs_b), .oVGA_R(r_b), .oVGA_G(g_b), .oVGA_B(b_b),
    .oFrameStart(fs_b)
  );

  vga_fb_scanout #(
    .H_VISIBLE(64), .H_FP(8), .H_SYNC(16), .H_BP(8),
    .V_VISIBLE(32), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .CELL_SHIFT(3), .FB_WIDTH(8), .ADDR_W(13)
  ) u_small (
    .Clock(Clock), .Reset(Reset), .oReadAddress(addr_s), .iReadData(rd_s),
    .oVGA_HS(hs_s), .oVGA_VS(vs_s), .oVGA_R(r_s), .oVGA_G(g_s), .oVGA_B(b_s),
    .oFrameStart(fs_s)
  );

  assign pins_b = {hs_b, vs_b, r_b, g_b, b_b, fs_b};
  assign pins_s = {hs_s, vs_s, r_s, g_s, b_s, fs_s};

  // Synchronous RAMs: data one cycle after the address.
  always @(posedge Clock) begin
    rd_b <= white ? 3'd7 : mem_b[addr_b];
    rd_s <= white ? 3'd7 : mem_s[addr_s[4:0]];
  end

  // Rising edges since reset release.
  always @(posedge Clock or negedge Reset)
    if (!Reset) k <= 0;
    else        k <= k + 1;

  function automatic logic [2:0] ram_val(bit sm, int a);
    if (white) return 3'd7;
    return sm ? mem_s[a] : mem_b[a];
  endfunction

  // Pins after k edges show pixel k-3: {HS, VS, R, G, B, FrameStart}.
  function automatic logic [5:0] exp_pins(tcfg_t c, bit sm, int kk);
    int htot, vtot, p, h, v;
    logic vis, hs, vs;
    if (kk < 3) return 6'b110000;
    htot = c.hv + c.hf + c.hsw + c.hb;
    vtot = c.vv + c.vf + c.vsw + c.vb;
    p = kk - 3;
    h = p % htot;
    v = (p / htot) % vtot;
    vis = (h < c.hv) && (v < c.vv);
    hs = !((h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hsw));
    vs = !((v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vsw));
    return {hs, vs, vis ? ram_val(sm, (v / 8) * c.fbw + h / 8) : 3'b000, (h == 0) && (v == 0)};
  endfunction

  // Address after k edges belongs to pixel k-1.
  function automatic int exp_addr(tcfg_t c, int kk);
    int htot, vtot, p, h, v;
    if (kk < 1) return 0;
    htot = c.hv + c.hf + c.hsw + c.hb;
    vtot = c.vv + c.vf + c.vsw + c.vb;
    p = kk - 1;
    h = p % htot;
    v = (p / htot) % vtot;
    return ((h < c.hv) && (v < c.vv)) ? (v / 8) * c.fbw + h / 8 : 0;
  endfunction

  task automatic release_reset();
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge Clock);
    n_checks++; if (pins_b !== 6'b110000) begin n_fail++; $display("FAIL rst_pins_big got %b exp 110000", pins_b); end
    n_checks++; if (addr_b !== 13'd0)     begin n_fail++; $display("FAIL rst_addr_big got %0d exp 0", addr_b); end
    n_checks++; if (pins_s !== 6'b110000) begin n_fail++; $display("FAIL rst_pins_small got %b exp 110000", pins_s); end
    n_checks++; if (addr_s !== 13'd0)     begin n_fail++; $display("FAIL rst_addr_small got %0d exp 0", addr_s); end
    Reset = 1'b1;
    repeat (50) @(negedge Clock);
    @(posedge Clock); #2;
    Reset = 1'b0; #1;
    n_checks++; if (pins_b !== 6'b110000) begin n_fail++; $display("FAIL async_rst_pins_big got %b exp 110000", pins_b); end
    n_checks++; if (addr_b !== 13'd0)     begin n_fail++; $display("FAIL async_rst_addr_big got %0d exp 0", addr_b); end
    n_checks++; if (pins_s !== 6'b110000) begin n_fail++; $display("FAIL async_rst_pins_small got %b exp 110000", pins_s); end
    n_checks++; if (addr_s !== 13'd0)     begin n_fail++; $display("FAIL async_rst_addr_small got %0d exp 0", addr_s); end
  endtask

  task automatic test_default_scan();
    logic [5:0] e;
    int ea, fall_k, n_fall, low_run, spot;
    bit last_hs;
    for (int i = 0; i < 4800; i++) mem_b[i] = 3'($urandom);
    release_reset();
    last_hs = 1'b1; fall_k = 0; n_fall = 0; low_run = 0;
    for (int i = 0; i < 800 * 20; i++) begin
      @(negedge Clock);
      e = exp_pins(CFG_B, 1'b0, k);
      n_checks++; if (pins_b !== e) begin n_fail++; $display("FAIL big_pins k=%0d got %b exp %b", k, pins_b, e); end
      ea = exp_addr(CFG_B, k);
      n_checks++; if (int'(addr_b) !== ea) begin n_fail++; $display("FAIL big_addr k=%0d got %0d exp %0d", k, addr_b, ea); end
      if (k == 8 || k == 9 || k == 642 || k == 6401) begin
        spot = (k == 9) ? 1 : (k == 6401) ? 80 : 0;
        n_checks++; if (int'(addr_b) !== spot) begin n_fail++; $display("FAIL big_addr_spot k=%0d got %0d exp %0d", k, addr_b, spot); end
      end
      if (last_hs && !hs_b) begin
        n_checks++;
        if (n_fall == 0 && k != 659) begin n_fail++; $display("FAIL hs_first_fall got k=%0d exp 659", k); end
        else if (n_fall > 0 && k - fall_k != 800) begin n_fail++; $display("FAIL hs_period got %0d exp 800", k - fall_k); end
        fall_k = k; n_fall++; low_run = 0;
      end
      if (!hs_b) low_run++;
      if (!last_hs && hs_b) begin
        n_checks++; if (low_run != 96) begin n_fail++; $display("FAIL hs_width got %0d exp 96", low_run); end
      end
      last_hs = hs_b;
    end
    n_checks++; if (n_fall != 20) begin n_fail++; $display("FAIL hs_count got %0d exp 20", n_fall); end
  endtask

  task automatic test_small_frames();
    logic [5:0] e;
    int ea, last_fs_k, n_fs, low_run, n_vfall;
    bit last_vs;
    for (int i = 0; i < 32; i++) mem_s[i] = 3'($urandom);
    release_reset();
    last_vs = 1'b1; last_fs_k = 0; n_fs = 0; low_run = 0; n_vfall = 0;
    for (int i = 0; i < 2 * FRM_S + 10; i++) begin
      @(negedge Clock);
      e = exp_pins(CFG_S, 1'b1, k);
      n_checks++; if (pins_s !== e) begin n_fail++; $display("FAIL small_pins k=%0d got %b exp %b", k, pins_s, e); end
      ea = exp_addr(CFG_S, k);
      n_checks++; if (int'(addr_s) !== ea) begin n_fail++; $display("FAIL small_addr k=%0d got %0d exp %0d", k, addr_s, ea); end
      if (k == 31 * HT_S + 63 + 1) begin
        n_checks++; if (addr_s !== 13'd31) begin n_fail++; $display("FAIL small_addr_max got %0d exp 31", addr_s); end
      end
      if (fs_s) begin
        n_checks++;
        if (n_fs == 0 && k != 3) begin n_fail++; $display("FAIL fs_first got k=%0d exp 3", k); end
        else if (n_fs > 0 && k - last_fs_k != FRM_S) begin n_fail++; $display("FAIL fs_period got %0d exp %0d", k - last_fs_k, FRM_S); end
        last_fs_k = k; n_fs++;
      end
      if (last_vs && !vs_s) begin
        n_checks++; if (k != 35 * HT_S + 3 + n_vfall * FRM_S) begin n_fail++; $display("FAIL vs_fall got k=%0d exp %0d", k, 35 * HT_S + 3 + n_vfall * FRM_S); end
        n_vfall++; low_run = 0;
      end
      if (!vs_s) low_run++;
      if (!last_vs && vs_s) begin
        n_checks++; if (low_run != 2 * HT_S) begin n_fail++; $display("FAIL vs_width got %0d exp %0d", low_run, 2 * HT_S); end
      end
      last_vs = vs_s;
    end
    n_checks++; if (n_fs != 3) begin n_fail++; $display("FAIL fs_count got %0d exp 3", n_fs); end
  endtask

  task automatic test_blanking();
    logic [5:0] e;
    white = 1'b1;
    release_reset();
    for (int i = 0; i < FRM_S + 10; i++) begin
      @(negedge Clock);
      e = exp_pins(CFG_S, 1'b1, k);
      n_checks++; if (pins_s !== e) begin n_fail++; $display("FAIL blank_small k=%0d got %b exp %b", k, pins_s, e); end
      e = exp_pins(CFG_B, 1'b0, k);
      n_checks++; if (pins_b !== e) begin n_fail++; $display("FAIL blank_big k=%0d got %b exp %b", k, pins_b, e); end
    end
    white = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [5:0] e;
    int ea;
    bit seen_fs;
    release_reset();
    for (int i = 0; i < 20 * HT_S + 30; i++) @(negedge Clock);
    Reset = 1'b0; #1;
    n_checks++; if (pins_s !== 6'b110000) begin n_fail++; $display("FAIL mid_rst_pins_small got %b exp 110000", pins_s); end
    n_checks++; if (addr_s !== 13'd0)     begin n_fail++; $display("FAIL mid_rst_addr_small got %0d exp 0", addr_s); end
    n_checks++; if (pins_b !== 6'b110000) begin n_fail++; $display("FAIL mid_rst_pins_big got %b exp 110000", pins_b); end
    n_checks++; if (addr_b !== 13'd0)     begin n_fail++; $display("FAIL mid_rst_addr_big got %0d exp 0", addr_b); end
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    seen_fs = 1'b0;
    for (int i = 0; i < FRM_S + 10; i++) begin
      @(negedge Clock);
      e = exp_pins(CFG_S, 1'b1, k);
      n_checks++; if (pins_s !== e) begin n_fail++; $display("FAIL mid_small_pins k=%0d got %b exp %b", k, pins_s, e); end
      ea = exp_addr(CFG_S, k);
      n_checks++; if (int'(addr_s) !== ea) begin n_fail++; $display("FAIL mid_small_addr k=%0d got %0d exp %0d", k, addr_s, ea); end
      if (k < 2000) begin
        e = exp_pins(CFG_B, 1'b0, k);
        n_checks++; if (pins_b !== e) begin n_fail++; $display("FAIL mid_big_pins k=%0d got %b exp %b", k, pins_b, e); end
      end
      if (fs_s && !seen_fs) begin
        seen_fs = 1'b1;
        n_checks++; if (k != 3) begin n_fail++; $display("FAIL mid_fs_first got k=%0d exp 3", k); end
      end
    end
    n_checks++; if (!seen_fs) begin n_fail++; $display("FAIL mid_fs_seen got 0 exp 1"); end
  endtask

  initial begin
    test_reset();
    test_default_scan();
    test_small_frames();
    test_blanking();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Display-side reader of the 80x60-cell, 3-bit-colour video RAM that the CPU's VGA instruction fills.
- Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock.
- Scales each RAM cell to an 8x8 pixel block and fetches cells through the RAM read port.
- Drives HS/VS/R/G/B to the connector with all outputs pipeline-aligned.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CELL_SHIFT, 3, log2 of cell size in pixels (8x8)
- FB_WIDTH, 80, cells per framebuffer row
- ADDR_W, 13, read address width

Ports:
- Clock  input  1  25 MHz pixel clock; all state on its rising edge
- Reset  input  1  asynchronous, active-low reset
- oReadAddress  output  ADDR_W  video RAM read address = row*FB_WIDTH + col
- iReadData  input  3  cell colour {R,G,B}; synchronous RAM, valid one cycle after the address is presented
- oVGA_HS  output  1  horizontal sync, active low
- oVGA_VS  output  1  vertical sync, active low
- oVGA_R  output  1  red
- oVGA_G  output  1  green
- oVGA_B  output  1  blue
- oFrameStart  output  1  one-cycle pulse while pixel (0,0) of a frame is on the pins

Behaviour:
- Counters:
  - hcount runs 0..H_TOTAL-1 (H_TOTAL = 800); vcount runs 0..V_TOTAL-1 (V_TOTAL = 525).
  - hcount increments every cycle. At hcount = 799 it wraps to 0 and vcount increments.
  - At (799, 524) both counters wrap to 0. Frame = 420000 cycles.
- Stage 0 decode, combinational from the counters:
  - visible = hcount<640 && vcount<480
  - hs_raw low for hcount 656..751
  - vs_raw low for vcount 490..491
- Stage 1, registered at the end of counter cycle n:
  - oReadAddress = (vcount>>3)*80 + (hcount>>3) when visible, else 0.
  - The *80 is computed as (r<<6)+(r<<4) at full ADDR_W width, no truncation. Maximum address is 4799.
  - visible, hs_raw and vs_raw are delayed in step.
- Stage 2: the RAM returns iReadData during cycle n+2. The delayed flags are registered once more.
- Stage 3: output registers capture at the end of cycle n+2, so pins show pixel (hcount, vcount) during cycle n+3.
  - {oVGA_R, oVGA_G, oVGA_B} = visible_d ? iReadData : 3'b000.
  - oVGA_HS and oVGA_VS are the delayed hs_raw and vs_raw.
- Fixed latency: 3 cycles from counter value to pins. HS, VS, RGB and oFrameStart are mutually aligned.
- oFrameStart is high for exactly one cycle, aligned with pixel (0,0) on the pins, once per frame.
- Colour mapping: iReadData[2]=R, [1]=G, [0]=B. Examples: 3'b010 green, 3'b101 magenta, 3'b111 white.
- RGB is forced to 0 whenever not visible, regardless of iReadData.
- Reset asserted (Reset=0), asynchronously and at any time including mid-line or mid-frame:
  - hcount=0, vcount=0, all pipeline flags cleared.
  - oReadAddress=0, oVGA_HS=1, oVGA_VS=1, RGB=0, oFrameStart=0.
- After reset release:
  - Counting restarts at (0,0).
  - The first oFrameStart pulse comes 3 cycles later.
  - No partial sync pulse is emitted during the pipeline fill.
- The RAM read port is read-only, with no backpressure or handshake. Writes by the CPU into the RAM are the RAM's concern. Tearing is acceptable.

Test Plan:
- HS timing: release reset, count cycles → oVGA_HS low for exactly 96 cycles, period 800 cycles; first falling edge at cycle 656+3 after release.
- VS timing: run two frames → oVGA_VS low for exactly 1600 cycles (2 lines) starting at line 490; oFrameStart pulses exactly 420000 cycles apart.
- Address generation: monitor oReadAddress → 0 for hcount 0..7 on line 0; 1 at hcount 8; 80 at line 8, hcount 0; 4799 at (639,479); 0 throughout blanking.
- Latency/alignment: RAM model returns iReadData = addr[2:0] one cycle after the address → pins show R,G,B = 000 for the first 8 visible pixels of line 0, then 001; colour changes land exactly on 8-pixel boundaries, 3 cycles after the counter.
- Blanking: iReadData held at 3'b111 → RGB = 111 during every visible pixel and 000 during every blanking pixel, including the first pixel after hcount wrap.
- Reset mid-frame: assert Reset at line 200, pixel 300 for 5 cycles → outputs go to HS=1, VS=1, RGB=0, address 0 immediately (asynchronously); after release, oFrameStart pulses 3 cycles later and the timing matches the first test.
